// File: rtl/fifo_pkg.sv
// Shared widths and read-mode constants for the single-clock FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_STD  = 32'd0;
  localparam int unsigned FIFO_FWFT = 32'd1;

  function automatic int unsigned ptr_w(input int unsigned d);
    return (d > 32'd1) ? $clog2(d) : 32'd1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned d);
    return $clog2(d + 32'd1);
  endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// FIFO storage: register array with one synchronous write port and one
// combinational read port. The array is deliberately not reset.
module fifo_sync_mem
  import fifo_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 8,
  parameter int unsigned aw    = ptr_w(depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem_q [depth];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_ctrl.sv
// Single-clock FIFO controller: pointers, fill count, registered flags,
// error pulses and read-data timing for standard or first-word-fall-through.
module fifo_sync_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned width    = 8,
  parameter int unsigned depth    = 8,
  parameter int unsigned fwft     = FIFO_STD,
  parameter int unsigned af_level = depth - 1,
  parameter int unsigned ae_level = 1
) (
  input  logic                       clk,
  input  logic                       rest_n,
  input  logic                       wr_en,
  input  logic [width-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [width-1:0]           rd_data,
  output logic                       rd_vld,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [cnt_w(depth)-1:0]    count,
  output logic                       wr_err,
  output logic                       rd_err
);

  localparam int unsigned          PTR_W     = ptr_w(depth);
  localparam int unsigned          CNT_W     = cnt_w(depth);
  localparam logic [PTR_W-1:0]     PTR_LAST  = PTR_W'(depth - 1);
  localparam logic [CNT_W-1:0]     DEPTH_C   = CNT_W'(depth);
  localparam logic [CNT_W-1:0]     AF_C      = CNT_W'(af_level);
  localparam logic [CNT_W-1:0]     AE_C      = CNT_W'(ae_level);
  localparam bit                   FWFT_MODE = (fwft == FIFO_FWFT);

  if (depth < 2 || af_level < 1 || af_level > depth || ae_level >= depth) begin : g_bad_params
    $error("fifo_sync_ctrl: illegal depth/af_level/ae_level combination");
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             af_q, af_d, ae_q, ae_d;
  logic             wr_err_q, wr_err_d, rd_err_q, rd_err_d;
  logic [width-1:0] rd_data_q, rd_data_d;
  logic             rd_vld_q, rd_vld_d;
  logic             wr_acc_s, rd_acc_s;
  logic [PTR_W-1:0] mem_raddr_s;
  logic [width-1:0] mem_rdata_s;

  fifo_sync_mem #(
    .width (width),
    .depth (depth),
    .aw    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc_s),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (mem_raddr_s),
    .rdata (mem_rdata_s)
  );

  // Accept decisions, pointer/count next state, flags and error pulses.
  // A full FIFO with read+write takes the read and refuses the write.
  always_comb begin
    wr_acc_s = wr_en && !full_q;
    rd_acc_s = rd_en && !empty_q;

    if (wr_acc_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_acc_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == {CNT_W{1'b0}});
    af_d     = (count_d >= AF_C);
    ae_d     = (count_d <= AE_C);
    wr_err_d = wr_en && full_q;
    rd_err_d = rd_en && empty_q;

    // Fall-through mode preloads the word that will be at the head next cycle
    if (FWFT_MODE) begin
      mem_raddr_s = rd_ptr_d;
    end else begin
      mem_raddr_s = rd_ptr_q;
    end
  end

  // Read-data register: head-of-queue preload in fall-through, pop data otherwise.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_vld_d  = 1'b0;
    if (FWFT_MODE) begin
      rd_vld_d = !empty_d;
      if (wr_acc_s && (wr_ptr_q == rd_ptr_d)) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = mem_rdata_s;
      end
    end else begin
      rd_vld_d = rd_acc_s;
      if (rd_acc_s) begin
        rd_data_d = mem_rdata_s;
      end else begin
        rd_data_d = rd_data_q;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      wr_err_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_data_q <= {width{1'b0}};
      rd_vld_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      wr_err_q  <= wr_err_d;
      rd_err_q  <= rd_err_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_vld       = rd_vld_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign wr_err       = wr_err_q;
  assign rd_err       = rd_err_q;

endmodule
